seq_magnitude_comparator: RTL and testbench

Parametrised, sequential successor to the team's 2-bit equality comparator: compares two WIDTH-bit unsigned operands CHUNK bits per clock, MSB chunk first, and reports eq/gt/lt with a start/done handshake. Optional early exit on the first mismatching chunk trades a fixed latency for a data-dependent one. Sits beside the combinational comparators for wide operands where a single-cycle compare does not meet timing.

---
 rtl/seq_magnitude_comparator.sv | 150 +++++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_magnitude_comparator.sv
// Sequential unsigned magnitude comparator: CHUNK bits per clock, MSB first.
// Reports eq/gt/lt and chunk count with a start/busy/done handshake.
module seq_magnitude_comparator #(
    parameter int WIDTH      = 16,
    parameter int CHUNK      = 2,
    parameter int EARLY_EXIT = 1,
    localparam int NCHUNK    = WIDTH / CHUNK,
    localparam int CW        = $clog2(NCHUNK + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [CW-1:0]    cycles
);

    typedef enum logic {
        IDLE,
        COMPARE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             mis_q, mis_d;
    logic             rgt_q, rgt_d;
    logic             rlt_q, rlt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic [CW-1:0]    cycles_q, cycles_d;

    // Operands are shifted left each step, so the active chunk is always on top.
    logic [CHUNK-1:0] ca, cb;
    logic             diff, chunk_gt, chunk_lt, new_mis, last, fin;

    // Chunk compare and completion decision for the current step.
    always_comb begin
        ca       = a_q[WIDTH-1 -: CHUNK];
        cb       = b_q[WIDTH-1 -: CHUNK];
        diff     = (ca != cb);
        chunk_gt = (ca > cb);
        chunk_lt = (ca < cb);
        new_mis  = diff && !mis_q;
        last     = (idx_q == CW'(NCHUNK - 1));
        fin      = ((EARLY_EXIT != 0) && diff) || last;
    end

    // Next-state and next-output computation for the IDLE/COMPARE machine.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        mis_d    = mis_q;
        rgt_d    = rgt_q;
        rlt_d    = rlt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        eq_d     = eq_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        cycles_d = cycles_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COMPARE;
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    mis_d   = 1'b0;
                    rgt_d   = 1'b0;
                    rlt_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            COMPARE: begin
                if (new_mis) begin
                    mis_d = 1'b1;
                    rgt_d = chunk_gt;
                    rlt_d = chunk_lt;
                end
                if (fin) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    cycles_d = idx_q + CW'(1);
                    eq_d     = !(mis_q || diff);
                    gt_d     = mis_q ? rgt_q : chunk_gt;
                    lt_d     = mis_q ? rlt_q : chunk_lt;
                end else begin
                    idx_d = idx_q + CW'(1);
                    a_d   = a_q << CHUNK;
                    b_d   = b_q << CHUNK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any operation at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            mis_q    <= 1'b0;
            rgt_q    <= 1'b0;
            rlt_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            mis_q    <= mis_d;
            rgt_q    <= rgt_d;
            rlt_q    <= rlt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            cycles_q <= cycles_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign eq     = eq_q;
    assign gt     = gt_q;
    assign lt     = lt_q;
    assign cycles = cycles_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator: default, full-scan
// and 2-bit/1-bit-chunk configurations.
module tb_seq_magnitude_comparator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        s0, busy0, done0, eq0, gt0, lt0;
    logic [15:0] a0, b0;
    logic [3:0]  cyc0;

    logic        s1, busy1, done1, eq1, gt1, lt1;
    logic [15:0] a1, b1;
    logic [3:0]  cyc1;

    logic        s2, busy2, done2, eq2, gt2, lt2;
    logic [1:0]  a2, b2;
    logic [1:0]  cyc2;

    int nerr = 0;
    int nchk = 0;

    seq_magnitude_comparator u0 (
        .clk(clk), .reset(reset), .start(s0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .eq(eq0), .gt(gt0), .lt(lt0),
        .cycles(cyc0)
    );

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(2), .EARLY_EXIT(0)) u1 (
        .clk(clk), .reset(reset), .start(s1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1),
        .cycles(cyc1)
    );

    seq_magnitude_comparator #(.WIDTH(2), .CHUNK(1), .EARLY_EXIT(1)) u2 (
        .clk(clk), .reset(reset), .start(s2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .eq(eq2), .gt(gt2), .lt(lt2),
        .cycles(cyc2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic done_of(input int s);
        case (s)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    // Counts edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(input int s, output int n);
        n = 0;
        while (done_of(s) !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic go0(input logic [15:0] aa, input logic [15:0] bb);
        a0 = aa;
        b0 = bb;
        s0 = 1'b1;
        @(posedge clk);
        #1;
        s0 = 1'b0;
    endtask

    task automatic op0(input string tag, input logic [15:0] aa,
                       input logic [15:0] bb, input int en,
                       input logic ee, input logic eg, input logic el);
        int n;
        go0(aa, bb);
        chk({tag, ".busy"}, busy0, 1);
        wait_done(0, n);
        chk({tag, ".lat"}, n, en);
        chk({tag, ".eq"}, eq0, ee);
        chk({tag, ".gt"}, gt0, eg);
        chk({tag, ".lt"}, lt0, el);
        chk({tag, ".cyc"}, cyc0, en);
        chk({tag, ".idle"}, busy0, 0);
    endtask

    initial begin
        int n;
        int seen;
        int en;
        reset = 1'b1;
        s0 = 0; s1 = 0; s2 = 0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst.busy", busy0, 0);
        chk("rst.done", done0, 0);
        chk("rst.eq", eq0, 0);
        chk("rst.gt", gt0, 0);
        chk("rst.lt", lt0, 0);
        chk("rst.cyc", cyc0, 0);

        op0("equal", 16'hA5A5, 16'hA5A5, 8, 1, 0, 0);
        op0("msbgt", 16'h8000, 16'h4000, 1, 0, 1, 0);
        op0("lsblt", 16'h0001, 16'h0003, 8, 0, 0, 1);

        // start with new operands while busy must be ignored
        go0(16'h0001, 16'h0002);
        @(posedge clk);
        #1;
        a0 = 16'hFFFF;
        b0 = 16'h0000;
        s0 = 1'b1;
        @(posedge clk);
        #1;
        s0 = 1'b0;
        wait_done(0, n);
        chk("ign.lat", n, 6);
        chk("ign.lt", lt0, 1);
        chk("ign.gt", gt0, 0);
        chk("ign.cyc", cyc0, 8);

        // start held high: second op accepted on the done cycle
        a0 = 16'h2000;
        b0 = 16'h1000;
        s0 = 1'b1;
        @(posedge clk);
        #1;
        a0 = 16'h0000;
        b0 = 16'h4000;
        wait_done(0, n);
        chk("hold1.lat", n, 2);
        chk("hold1.gt", gt0, 1);
        chk("hold1.cyc", cyc0, 2);
        chk("hold1.busy", busy0, 0);
        @(posedge clk);
        #1;
        chk("hold2.busy", busy0, 1);
        chk("hold2.done", done0, 0);
        s0 = 1'b0;
        wait_done(0, n);
        chk("hold2.lat", n, 1);
        chk("hold2.lt", lt0, 1);
        chk("hold2.cyc", cyc0, 1);

        // reset during the third compare cycle
        go0(16'hA5A5, 16'hA5A5);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mid.busy", busy0, 0);
        chk("mid.done", done0, 0);
        chk("mid.eq", eq0, 0);
        chk("mid.gt", gt0, 0);
        chk("mid.lt", lt0, 0);
        chk("mid.cyc", cyc0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done0 !== 1'b0 || busy0 !== 1'b0) seen = 1;
        end
        chk("mid.quiet", seen, 0);
        op0("after", 16'h0005, 16'h0005, 8, 1, 0, 0);

        // full scan: first mismatch wins over a later opposite chunk
        a1 = 16'hC000;
        b1 = 16'h0001;
        s1 = 1'b1;
        @(posedge clk);
        #1;
        s1 = 1'b0;
        wait_done(1, n);
        chk("full.lat", n, 8);
        chk("full.gt", gt1, 1);
        chk("full.lt", lt1, 0);
        chk("full.eq", eq1, 0);
        chk("full.cyc", cyc1, 8);

        // 2-bit operands compared one bit per cycle
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a2 = 2'(i);
                b2 = 2'(j);
                s2 = 1'b1;
                @(posedge clk);
                #1;
                s2 = 1'b0;
                wait_done(2, n);
                en = (i[1] != j[1]) ? 1 : 2;
                chk($sformatf("w2.%0d%0d.lat", i, j), n, en);
                chk($sformatf("w2.%0d%0d.eq", i, j), eq2, (i == j) ? 1 : 0);
                chk($sformatf("w2.%0d%0d.gt", i, j), gt2, (i > j) ? 1 : 0);
                chk($sformatf("w2.%0d%0d.lt", i, j), lt2, (i < j) ? 1 : 0);
                chk($sformatf("w2.%0d%0d.cyc", i, j), cyc2, en);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
